// File: rtl/chunked_serial_subtractor.sv
// Multi-cycle unsigned subtractor: W bits per clock, LSB chunk first, with a registered
// borrow rippling between chunks. Valid/ready handshake on both the input and output side.
module chunked_serial_subtractor #(
  parameter int N = 56,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy
);

  localparam int NCH = N / W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((W < 1) || (N % W != 0)) begin : g_bad_chunk_width
    $error("chunked_serial_subtractor: N must be a positive multiple of W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [NCH-1:0][W-1:0]   r_a;
  logic [NCH-1:0][W-1:0]   r_b;
  logic [NCH-1:0][W-1:0]   r_d;
  logic                    r_br;
  logic                    r_bout;
  logic [CW-1:0]           r_cnt;

  logic                    w_accept;
  logic                    w_last;
  logic [W:0]              w_diff;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(NCH - 1));

  // Extra top bit of the W+1-bit difference is the chunk's borrow-out.
  assign w_diff = {1'b0, r_a[r_cnt]} - {1'b0, r_b[r_cnt]} - {{W{1'b0}}, r_br};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first means every path drives w_state_next, so
  // no latch is inferred when a case branch leaves it untouched.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // NOTE: operand and result registers are plain flops, not a RAM, so clearing them
  // on reset costs nothing and guarantees d/bout read zero after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_d[r_cnt] <= w_diff[W-1:0];
          r_br       <= w_diff[W];
          r_cnt      <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout <= w_diff[W];
          end
        end
        default: ;
      endcase
    end
  end

  // Held low during reset so nothing can be accepted by an edge that races rst release.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign d         = r_d;
  assign bout      = r_bout;

endmodule

// File: tb/tb_chunked_serial_subtractor.sv
// Self-checking bench: directed corner cases plus randomized traffic on W=8, W=56 and W=1
// instances, each result compared against plain (N+1)-bit arithmetic a - b - bin.
module tb_chunked_serial_subtractor;

  localparam int N       = 56;
  localparam int W       = 8;
  localparam int NCH     = N / W;
  localparam int MAIN_OPS = 1000;
  localparam int ALT_OPS  = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         rst_alt;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunked_serial_subtractor #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rand56();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N-1:0];
  endfunction

  function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic bi);
    return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
  endfunction

  // One complete operation on the main instance: accept, latency, stall, handshake.
  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                        input logic op_bin, input int stall, input bit toggle);
    logic [N:0]   exp;
    logic [N-1:0] d_hold;
    logic         bout_hold;
    logic         busy_ok;
    logic         stable;
    int           n;
    int           lat;
    exp = ref_sub(op_a, op_b, op_bin);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    bin      = op_bin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = rand56();
    b        = rand56();
    bin      = 1'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, NCH);
    check("busy_while_running", busy_ok, 1);
    d_hold    = d;
    bout_hold = bout;
    stable    = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        a        = rand56();
        b        = rand56();
        bin      = 1'($urandom);
      end
      @(posedge clk); #1;
      if (d !== d_hold || bout !== bout_hold || !out_valid || in_ready) stable = 1'b0;
    end
    check("done_hold_stable", stable, 1);
    check("d", d, exp[N-1:0]);
    check("bout", bout, exp[N]);
    out_ready = 1'b1;
    if (toggle) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_handshake_valid_busy", {out_valid, busy}, 2'b00);
    in_valid = 1'b0;
  endtask

  // Independent random traffic on the full-width and bit-serial configurations.
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int GW   = (g == 0) ? N : 1;
    localparam int GLAT = N / GW;
    logic         iv;
    logic         irdy;
    logic         ov;
    logic         ordy;
    logic         bi;
    logic         bo;
    logic         bz;
    logic         done;
    logic [N-1:0] aa;
    logic [N-1:0] bb;
    logic [N-1:0] dd;

    chunked_serial_subtractor #(.N(N), .W(GW)) u_dut (
      .clk       (clk),
      .rst       (rst_alt),
      .in_valid  (iv),
      .in_ready  (irdy),
      .a         (aa),
      .b         (bb),
      .bin       (bi),
      .out_valid (ov),
      .out_ready (ordy),
      .d         (dd),
      .bout      (bo),
      .busy      (bz)
    );

    initial begin
      logic [N:0] exp;
      int         n;
      int         lat;
      iv   = 1'b0;
      ordy = 1'b0;
      aa   = '0;
      bb   = '0;
      bi   = 1'b0;
      done = 1'b0;
      @(negedge rst_alt);
      @(posedge clk); #1;
      for (int k = 0; k < ALT_OPS; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          aa = '0;
          bb = N'(1);
        end else begin
          aa = rand56();
          bb = rand56();
        end
        bi  = 1'($urandom);
        exp = ref_sub(aa, bb, bi);
        n = 0;
        while (!irdy && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        iv = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        aa  = rand56();
        bb  = rand56();
        lat = 0;
        while (!ov && lat < 200) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("w%0d_latency", GW), lat, GLAT);
        check($sformatf("w%0d_d", GW), dd, exp[N-1:0]);
        check($sformatf("w%0d_bout", GW), bo, exp[N]);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check($sformatf("w%0d_busy_after_out", GW), bz, 0);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    rst_alt   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_d", d, 0);
    check("reset_bout", bout, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    #24;
    rst     = 1'b0;
    rst_alt = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    run_op(N'(56'h1000), N'(1), 1'b0, 0, 1'b0);
    run_op('0, N'(1), 1'b0, 2, 1'b0);
    run_op(56'h12_3456_78AB_CDEF, 56'h12_3456_78AB_CDEF, 1'b1, 1, 1'b0);
    run_op(56'h12_3456_78AB_CDEF, 56'h12_3456_78AB_CDEF, 1'b0, 0, 1'b0);
    run_op(rand56(), rand56(), 1'b1, 5, 1'b1);
    run_op({N{1'b1}}, {N{1'b1}}, 1'b1, 0, 1'b0);

    // Abort an operation three RUN edges in.
    in_valid = 1'b1;
    a        = rand56();
    b        = rand56();
    bin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_d", d, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_abort", in_ready, 1);
    @(posedge clk); #1;
    check("no_valid_after_abort", out_valid, 0);
    run_op(N'(5), N'(3), 1'b0, 0, 1'b0);

    for (int k = 0; k < MAIN_OPS; k++) begin
      case ($urandom_range(0, 7))
        0:       run_op('0, N'(1), 1'($urandom), $urandom_range(0, 3), 1'b0);
        1:       run_op({N{1'b1}}, rand56(), 1'($urandom), $urandom_range(0, 3), 1'b1);
        default: run_op(rand56(), rand56(), 1'($urandom), $urandom_range(0, 3),
                        1'($urandom));
      endcase
    end

    n = 0;
    while (!(g_alt[0].done && g_alt[1].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("alt_instances_done", {g_alt[0].done, g_alt[1].done}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
